// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS data-width registers with byte strobes.
// Read-only slots carry no storage and read back their hw_in slice instead.
module axi4lite_reg_slave #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [ADDRWIDTH-1:0]          AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [DATAWIDTH-1:0]          WDATA,
    input  logic [DATAWIDTH/8-1:0]        WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [ADDRWIDTH-1:0]          ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [DATAWIDTH-1:0]          RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [NUM_REGS*DATAWIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATAWIDTH-1:0] hw_in
);
    localparam int STRBW = DATAWIDTH / 8;
    localparam int OFFW = $clog2(STRBW);
    localparam int IDXW = ADDRWIDTH - OFFW;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;
    logic ready_en;
    logic aw_held, w_held;
    logic [IDXW-1:0] aw_idx;
    logic [DATAWIDTH-1:0] w_data;
    logic [STRBW-1:0] w_strb;
    logic aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
    logic [IDXW-1:0] ar_idx;
    logic [DATAWIDTH-1:0] rd_val;
    logic rd_ok;
    logic unused_addr_lsbs;

    function automatic logic idx_writable(input logic [IDXW-1:0] idx);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == IDXW'(i)) ok = !RO_MASK[i];
        return ok;
    endfunction

    assign unused_addr_lsbs = ^{AWADDR[OFFW-1:0], ARADDR[OFFW-1:0]};
    assign ar_idx = ARADDR[ADDRWIDTH-1:OFFW];

    // Keeps every READY low while reset is applied, high from the first edge after release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign AWREADY = ready_en && (w_state == W_IDLE) && !aw_held;
    assign WREADY  = ready_en && (w_state == W_IDLE) && !w_held;
    assign ARREADY = ready_en && (r_state == R_IDLE);
    assign BVALID  = (w_state == W_RESP);
    assign RVALID  = (r_state == R_DATA);

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign wr_ok = idx_writable(aw_idx);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        wr_fire = 1'b0;
        case (w_state)
            W_IDLE: if (aw_held && w_held) begin
                wr_fire = 1'b1;
                w_state_nxt = W_RESP;
            end
            W_RESP: if (BREADY) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held <= 1'b0;
            w_held <= 1'b0;
            BRESP <= RESP_OKAY;
        end else if (wr_fire) begin
            aw_held <= 1'b0;
            w_held <= 1'b0;
            BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs)  w_held <= 1'b1;
        end
    end

    // Payload latches are qualified by the held flags, so they need no reset.
    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_idx <= AWADDR[ADDRWIDTH-1:OFFW];
        if (w_hs) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_q[i*DATAWIDTH +: DATAWIDTH] = '0;
        end else begin : g_rw
            logic [DATAWIDTH-1:0] q;
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    q <= '0;
                end else if (wr_fire && (aw_idx == IDXW'(i))) begin
                    for (int k = 0; k < STRBW; k++)
                        if (w_strb[k]) q[k*8 +: 8] <= w_data[k*8 +: 8];
                end
            end
            assign reg_q[i*DATAWIDTH +: DATAWIDTH] = q;
        end
    end

    // Read mux samples reg_q before any same-edge commit lands.
    always_comb begin
        rd_val = '0;
        rd_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDXW'(i)) begin
                rd_ok = 1'b1;
                rd_val = RO_MASK[i] ? hw_in[i*DATAWIDTH +: DATAWIDTH]
                                    : reg_q[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
            R_DATA: if (RREADY) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            RDATA <= rd_val;
            RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: 16 x 32-bit registers, register 0 read-only.
module tb_axi4lite_reg_slave;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0001;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [AW-1:0] AWADDR = '0;
    logic AWVALID = 1'b0;
    logic AWREADY;
    logic [DW-1:0] WDATA = '0;
    logic [DW/8-1:0] WSTRB = '0;
    logic WVALID = 1'b0;
    logic WREADY;
    logic [1:0] BRESP;
    logic BVALID;
    logic BREADY = 1'b0;
    logic [AW-1:0] ARADDR = '0;
    logic ARVALID = 1'b0;
    logic ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0] RRESP;
    logic RVALID;
    logic RREADY = 1'b0;
    logic [NR*DW-1:0] reg_q;
    logic [NR*DW-1:0] hw_in;

    int checks = 0;
    int errors = 0;
    logic [NR*DW-1:0] exp_q = '0;

    axi4lite_reg_slave #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .hw_in(hw_in)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, a_rdy, w_rdy;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            a_rdy = AWVALID && AWREADY;
            w_rdy = WVALID && WREADY;
            tick; n++;
            if (a_rdy) begin aw_done = 1; AWVALID = 1'b0; end
            if (w_rdy) begin w_done = 1; WVALID = 1'b0; end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        while (!BVALID && n < 40) begin tick; n++; end
        ok = BVALID;
        resp = BRESP;
        tick;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp, output bit ok);
        bit a_done, a_rdy;
        int n;
        a_done = 0; n = 0;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        while (!a_done && n < 20) begin
            a_rdy = ARVALID && ARREADY;
            tick; n++;
            if (a_rdy) begin a_done = 1; ARVALID = 1'b0; end
        end
        ARVALID = 1'b0;
        while (!RVALID && n < 40) begin tick; n++; end
        ok = RVALID;
        data = RDATA;
        resp = RRESP;
        tick;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (AWREADY !== 1'b0) begin errors++; $display("FAIL rst_awready got %b exp 0", AWREADY); end
        checks++; if (WREADY !== 1'b0) begin errors++; $display("FAIL rst_wready got %b exp 0", WREADY); end
        checks++; if (ARREADY !== 1'b0) begin errors++; $display("FAIL rst_arready got %b exp 0", ARREADY); end
        checks++; if ({BVALID, RVALID} !== 2'b00) begin errors++; $display("FAIL rst_valids got %b exp 00", {BVALID, RVALID}); end
        checks++; if ({BRESP, RRESP} !== 4'b0000) begin errors++; $display("FAIL rst_resps got %b exp 0000", {BRESP, RRESP}); end
        checks++; if (RDATA !== '0) begin errors++; $display("FAIL rst_rdata got %h exp 0", RDATA); end
        checks++; if (reg_q !== '0) begin errors++; $display("FAIL rst_regq got %h exp 0", reg_q); end
        ARESET = 1'b0;
        tick;
        checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin errors++; $display("FAIL rel_readys got %b exp 111", {AWREADY, WREADY, ARREADY}); end
        checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL rel_bvalid got %b exp 0", BVALID); end
    endtask

    task automatic test_same_cycle_write;
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        AWADDR = 8'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL sc_bvalid_early got %b exp 0", BVALID); end
        tick;
        checks++; if (BVALID !== 1'b1) begin errors++; $display("FAIL sc_bvalid got %b exp 1", BVALID); end
        checks++; if (BRESP !== 2'b00) begin errors++; $display("FAIL sc_bresp got %b exp 00", BRESP); end
        tick;
        checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL sc_bvalid_clear got %b exp 0", BVALID); end
        exp_q[63:32] = 32'hDEADBEEF;
        checks++; if (reg_q[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_regq1 got %h exp deadbeef", reg_q[63:32]); end
        axi_read(8'h04, d, r, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sc_read_timeout got 0 exp 1"); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_rdata got %h exp deadbeef", d); end
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL sc_rresp got %b exp 00", r); end
    endtask

    task automatic test_data_first;
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        axi_write(8'h08, 32'hAAAAAAAA, 4'hF, r, ok);
        checks++; if (!ok || r !== 2'b00) begin errors++; $display("FAIL df_init got ok=%0d resp=%b exp ok=1 resp=00", ok, r); end
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1; BREADY = 1'b1;
        tick;
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({WREADY, AWREADY, BVALID} !== 3'b010) begin errors++; $display("FAIL df_wait%0d got w/aw/b=%b exp 010", i, {WREADY, AWREADY, BVALID}); end
            tick;
        end
        AWADDR = 8'h08; AWVALID = 1'b1;
        tick;
        AWVALID = 1'b0;
        tick;
        checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL df_bresp got v=%b r=%b exp v=1 r=00", BVALID, BRESP); end
        tick;
        exp_q[95:64] = 32'hAA22AA44;
        axi_read(8'h08, d, r, ok);
        checks++; if (!ok || d !== 32'hAA22AA44) begin errors++; $display("FAIL df_rdata got %h exp aa22aa44", d); end
        checks++; if (reg_q !== exp_q) begin errors++; $display("FAIL df_regq got %h exp %h", reg_q, exp_q); end
    endtask

    task automatic test_strobe_zero;
        logic [1:0] r; bit ok;
        axi_write(8'h04, 32'hFFFFFFFF, 4'h0, r, ok);
        checks++; if (!ok || r !== 2'b00) begin errors++; $display("FAIL sz_bresp got ok=%0d resp=%b exp ok=1 resp=00", ok, r); end
        checks++; if (reg_q !== exp_q) begin errors++; $display("FAIL sz_regq got %h exp %h", reg_q, exp_q); end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        axi_write(8'h40, 32'h12345678, 4'hF, r, ok);
        checks++; if (!ok || r !== 2'b10) begin errors++; $display("FAIL oor_bresp got ok=%0d resp=%b exp ok=1 resp=10", ok, r); end
        checks++; if (reg_q !== exp_q) begin errors++; $display("FAIL oor_regq got %h exp %h", reg_q, exp_q); end
        axi_read(8'h40, d, r, ok);
        checks++; if (!ok || d !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", d); end
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_rresp got %b exp 10", r); end
    endtask

    task automatic test_read_only;
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        axi_write(8'h00, 32'h12345678, 4'hF, r, ok);
        checks++; if (!ok || r !== 2'b10) begin errors++; $display("FAIL ro_bresp got ok=%0d resp=%b exp ok=1 resp=10", ok, r); end
        axi_read(8'h00, d, r, ok);
        checks++; if (!ok || d !== 32'h0000CAFE) begin errors++; $display("FAIL ro_rdata got %h exp 0000cafe", d); end
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL ro_rresp got %b exp 00", r); end
        checks++; if (reg_q[31:0] !== 32'h0) begin errors++; $display("FAIL ro_regq0 got %h exp 0", reg_q[31:0]); end
    endtask

    task automatic test_backpressure;
        AWADDR = 8'h0C; WDATA = 32'h0F0F0F0F; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({BVALID, BRESP, AWREADY} !== 4'b1000) begin errors++; $display("FAIL bp_b%0d got v/resp/awr=%b exp 1000", i, {BVALID, BRESP, AWREADY}); end
            tick;
        end
        BREADY = 1'b1;
        tick;
        checks++; if ({BVALID, AWREADY} !== 2'b01) begin errors++; $display("FAIL bp_b_done got v/awr=%b exp 01", {BVALID, AWREADY}); end
        exp_q[127:96] = 32'h0F0F0F0F;
        ARADDR = 8'h0C; ARVALID = 1'b1; RREADY = 1'b0;
        tick;
        ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (RVALID !== 1'b1 || RDATA !== 32'h0F0F0F0F || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
                errors++; $display("FAIL bp_r%0d got v=%b d=%h r=%b arr=%b exp v=1 d=0f0f0f0f r=00 arr=0", i, RVALID, RDATA, RRESP, ARREADY);
            end
            tick;
        end
        RREADY = 1'b1;
        tick;
        checks++; if ({RVALID, ARREADY} !== 2'b01) begin errors++; $display("FAIL bp_r_done got v/arr=%b exp 01", {RVALID, ARREADY}); end
    endtask

    task automatic test_concurrent;
        AWADDR = 8'h0C; WDATA = 32'h55AA55AA; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b0;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 8'h0C; ARVALID = 1'b1;
        tick;
        ARVALID = 1'b0;
        checks++; if (RVALID !== 1'b1 || RDATA !== 32'h0F0F0F0F) begin errors++; $display("FAIL cc_rdata got v=%b d=%h exp v=1 d=0f0f0f0f", RVALID, RDATA); end
        checks++; if (BVALID !== 1'b1) begin errors++; $display("FAIL cc_bvalid got %b exp 1", BVALID); end
        exp_q[127:96] = 32'h55AA55AA;
        checks++; if (reg_q !== exp_q) begin errors++; $display("FAIL cc_regq got %h exp %h", reg_q, exp_q); end
        RREADY = 1'b1;
        tick;
        checks++; if ({RVALID, BVALID} !== 2'b00) begin errors++; $display("FAIL cc_done got r/b=%b exp 00", {RVALID, BVALID}); end
    endtask

    task automatic test_reset_mid;
        AWADDR = 8'h04; AWVALID = 1'b1; BREADY = 1'b1;
        tick;
        AWVALID = 1'b0;
        checks++; if ({AWREADY, WREADY} !== 2'b01) begin errors++; $display("FAIL rm_held got aw/w=%b exp 01", {AWREADY, WREADY}); end
        tick;
        ARESET = 1'b1;
        #1;
        checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin errors++; $display("FAIL rm_async_readys got %b exp 000", {AWREADY, WREADY, ARREADY}); end
        checks++; if (reg_q !== '0) begin errors++; $display("FAIL rm_async_regq got %h exp 0", reg_q); end
        tick;
        ARESET = 1'b0;
        tick;
        exp_q = '0;
        checks++; if ({AWREADY, BVALID} !== 2'b10) begin errors++; $display("FAIL rm_release got awr/b=%b exp 10", {AWREADY, BVALID}); end
        checks++; if (reg_q !== exp_q) begin errors++; $display("FAIL rm_regq got %h exp 0", reg_q); end
        WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
        tick;
        WVALID = 1'b0;
        tick; tick;
        checks++; if (BVALID !== 1'b0) begin errors++; $display("FAIL rm_no_commit got bvalid=%b exp 0", BVALID); end
        checks++; if (reg_q !== exp_q) begin errors++; $display("FAIL rm_regq_after_w got %h exp 0", reg_q); end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = 32'h5A5A0000 | i;
        hw_in[31:0] = 32'h0000CAFE;
        test_reset;
        test_same_cycle_write;
        test_data_first;
        test_strobe_zero;
        test_out_of_range;
        test_read_only;
        test_backpressure;
        test_concurrent;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_reg_slave.md
AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

Interface
REQ-001 The module SHALL have the parameter ADDRWIDTH, default 8, giving the AXI address width in bits.
REQ-002 The module SHALL have the parameter DATAWIDTH, default 32, giving the data width; only 32 and 64 are legal.
REQ-003 The module SHALL have the parameter NUM_REGS, default 16, giving the register count; legal range is 1..2^(ADDRWIDTH-log2(DATAWIDTH/8)).
REQ-004 The module SHALL have the parameter RO_MASK [NUM_REGS-1:0], default 0, where bit i=1 marks register i read-only.
REQ-005 The module SHALL have the port ACLK, input, 1 bit: the single clock; all state is on the rising edge.
REQ-006 The module SHALL have the port ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have the ports AWADDR in [ADDRWIDTH], AWVALID in 1, and AWREADY out 1, forming the write address channel.
REQ-008 The module SHALL have the ports WDATA in [DATAWIDTH], WSTRB in [DATAWIDTH/8], WVALID in 1, and WREADY out 1, forming the write data channel.
REQ-009 The module SHALL have the ports BRESP out [2], BVALID out 1, and BREADY in 1, forming the write response channel.
REQ-010 The module SHALL have the ports ARADDR in [ADDRWIDTH], ARVALID in 1, and ARREADY out 1, forming the read address channel.
REQ-011 The module SHALL have the ports RDATA out [DATAWIDTH], RRESP out [2], RVALID out 1, and RREADY in 1, forming the read data channel.
REQ-012 The module SHALL have the port reg_q, output, [NUM_REGS*DATAWIDTH]: the current value of every read-write register; register i occupies slice i.
REQ-013 The module SHALL have the port hw_in, input, [NUM_REGS*DATAWIDTH]: the read value of every read-only register; slice i is used when RO_MASK[i]=1.

Function
REQ-014 Decode SHALL use index = addr[ADDRWIDTH-1:log2(DATAWIDTH/8)]; the low byte-offset bits SHALL be ignored.
REQ-015 An index >= NUM_REGS SHALL be out of range.
REQ-016 The write path SHALL keep two flags, aw_held and w_held, plus latched AWADDR, WDATA and WSTRB.
REQ-017 Write FSM states SHALL be W_IDLE and W_RESP.
REQ-018 In W_IDLE: AWREADY = !aw_held and WREADY = !w_held; AW and W SHALL be accepted in either order or in the same cycle.
REQ-019 In W_IDLE, at the edge where aw_held and w_held are both 1, the write SHALL commit, both flags SHALL clear, the FSM SHALL enter W_RESP, and BVALID SHALL be set to 1.
REQ-020 Commit, in-range read-write target: each byte lane k with WSTRB[k]=1 SHALL update; lanes with WSTRB[k]=0 SHALL be unchanged; WSTRB=0 SHALL give OKAY with no change.
REQ-021 Commit, out-of-range or read-only target: no register SHALL change; BRESP SHALL be SLVERR (2'b10).
REQ-022 Commit, all other cases: BRESP SHALL be OKAY (2'b00).
REQ-023 In W_RESP: AWREADY = WREADY = 0; BVALID and BRESP SHALL hold until BVALID && BREADY; at that edge the FSM SHALL return to W_IDLE.
REQ-024 Write latency: AW and W accepted at edge N SHALL give BVALID=1 after edge N+1.
REQ-025 Read FSM states SHALL be R_IDLE and R_DATA.
REQ-026 In R_IDLE, ARREADY SHALL be 1.
REQ-027 At the ARVALID && ARREADY edge, RDATA and RRESP SHALL be registered and the FSM SHALL enter R_DATA with RVALID=1.
REQ-028 RDATA source: reg_q slice if RO_MASK[i]=0; hw_in slice if RO_MASK[i]=1; 0 with RRESP=SLVERR if out of range.
REQ-029 In R_DATA: ARREADY=0; RDATA, RRESP and RVALID SHALL hold until RVALID && RREADY; at that edge the FSM SHALL return to R_IDLE.
REQ-030 Read latency: RVALID=1 SHALL follow the AR handshake edge; the next AR SHALL be accepted no earlier than the cycle after the R handshake.
REQ-031 The read and write FSMs SHALL be independent and SHALL be able to operate concurrently.
REQ-032 If an AR handshake and a write commit to the same index occur on the same edge, RDATA SHALL return the pre-write value.
REQ-033 All outputs SHALL be driven from registers; there SHALL be no combinational path from a *VALID/*READY input to a *READY/*VALID output.
REQ-034 Read-only registers SHALL hold no storage; their reg_q slices SHALL read 0.

Reset
REQ-035 ARESET=1 SHALL act immediately, independent of ACLK.
REQ-036 On reset: both FSMs SHALL go to idle; aw_held=w_held=0; all registers=0.
REQ-037 On reset, outputs SHALL be: BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, AWREADY=WREADY=ARREADY=1 from the first cycle after deassertion, and 0 while ARESET=1.
REQ-038 A reset mid-transaction SHALL discard the transaction: no partial commit, and no B or R beat after release.

Verification
REQ-039 Scenario (defaults): write 0x04 data 0xDEADBEEF WSTRB 4'hF with AW and W in the same cycle, BREADY=1 -> BVALID two edges later with BRESP=00; reg_q[63:32]=0xDEADBEEF; read 0x04 -> RDATA=0xDEADBEEF, RRESP=00.
REQ-040 Scenario: W 0x11223344 presented 3 cycles before AW 0x08, WSTRB 4'b0101 on a register holding 0xAAAAAAAA -> register reads 0xAA22AA44; WREADY=0 while w_held=1.
REQ-041 Scenario: write 0x40 (index 16) and read 0x40 -> BRESP=10 and no reg_q change; RDATA=0 with RRESP=10.
REQ-042 Scenario: RO_MASK=16'h0001, hw_in[31:0]=0x0000CAFE; write 0x00 then read 0x00 -> BRESP=10, RDATA=0x0000CAFE, reg_q[31:0]=0.
REQ-043 Scenario: BREADY held 0 for 5 cycles, then RREADY held 0 for 5 cycles -> BVALID/BRESP and RVALID/RDATA stable throughout; AWREADY=0 and ARREADY=0 respectively until the handshake.
REQ-044 Scenario: assert ARESET one cycle after an AW handshake, before W -> after release no BVALID, aw_held=0, and all registers=0.
